// File: rtl/fir_ctrl_pkg.sv
// +----------------------------------------------------------------------+
// | fir_ctrl_pkg : shared types and defaults for the FIR coefficient     |
// |                load sequencer.                                       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package fir_ctrl_pkg;

  localparam int NUM_COEFFS  = 4;
  localparam int CNUM_W      = 2;
  localparam int ACK_TIMEOUT = 16;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_IDLE = 3'd1,
    S_ISSUE     = 3'd2,
    S_WAIT_HI   = 3'd3,
    S_WAIT_LO   = 3'd4,
    S_CLEAR     = 3'd5
  } fir_load_state_t;

endpackage

`default_nettype wire

// File: rtl/ack_timer.sv
// +----------------------------------------------------------------------+
// | ack_timer : clearable up-counter that flags the cycle on which it    |
// |             reaches ACK_TIMEOUT, then rolls over to zero.            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module ack_timer #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic hit_o
);

  localparam int            W    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [W-1:0]  LAST = W'(ACK_TIMEOUT - 1);

  logic [W-1:0] cnt_q;

  // The increment that would reach ACK_TIMEOUT is the expiry cycle.
  assign hit_o = en_i && (cnt_q == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i || hit_o) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fir_coeff_load_ctrl.sv
// +----------------------------------------------------------------------+
// | fir_coeff_load_ctrl : walks all FIR taps through a modwait-handshaked|
// |                       load sequence and arbitrates incoming samples. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module fir_coeff_load_ctrl #(
  parameter int NUM_COEFFS  = fir_ctrl_pkg::NUM_COEFFS,
  parameter int CNUM_W      = fir_ctrl_pkg::CNUM_W,
  parameter int ACK_TIMEOUT = fir_ctrl_pkg::ACK_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              new_coeff_set,
  input  logic              data_ready_in,
  input  logic              modwait,
  output logic [CNUM_W-1:0] coeff_num,
  output logic              load_coeff,
  output logic              data_ready_out,
  output logic              clear_new_coeff,
  output logic              busy,
  output logic              load_err
);

  import fir_ctrl_pkg::*;

  localparam logic [CNUM_W-1:0] LAST_TAP = CNUM_W'(NUM_COEFFS - 1);

  fir_load_state_t   state_q, state_d;
  logic [CNUM_W-1:0] coeff_num_q, coeff_num_d;
  logic              load_err_q, load_err_d;
  logic              pend_q, pend_d;
  logic              guard_q, guard_d;
  logic              dro_q, dro_d;
  logic              load_q, clear_q, busy_q;
  logic              tmr_clr, tmr_en, tmr_hit;

  ack_timer #(
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_ack_timer (
    .clk   (clk),
    .rst   (rst),
    .clr_i (tmr_clr),
    .en_i  (tmr_en),
    .hit_o (tmr_hit)
  );

  assign tmr_en = (state_q == S_WAIT_HI) || (state_q == S_WAIT_LO);

  always_comb begin
    state_d     = state_q;
    coeff_num_d = coeff_num_q;
    load_err_d  = load_err_q;
    tmr_clr     = 1'b0;

    case (state_q)
      S_IDLE: begin
        // guard_q masks the slave's stale new_coeff_set right after CLEAR
        if (new_coeff_set && !guard_q) begin
          if (modwait) begin
            state_d = S_WAIT_IDLE;
          end else begin
            state_d     = S_ISSUE;
            coeff_num_d = '0;
            load_err_d  = 1'b0;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (!modwait) begin
          state_d     = S_ISSUE;
          coeff_num_d = '0;
          load_err_d  = 1'b0;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT_HI;
        tmr_clr = 1'b1;
      end
      S_WAIT_HI: begin
        if (modwait) begin
          state_d = S_WAIT_LO;
          tmr_clr = 1'b1;
        end else if (tmr_hit) begin
          load_err_d = 1'b1;
          state_d    = S_CLEAR;
        end
      end
      S_WAIT_LO: begin
        if (!modwait) begin
          if (coeff_num_q == LAST_TAP) begin
            state_d = S_CLEAR;
          end else begin
            coeff_num_d = coeff_num_q + 1'b1;
            state_d     = S_ISSUE;
          end
        end else if (tmr_hit) begin
          load_err_d = 1'b1;
          state_d    = S_CLEAR;
        end
      end
      S_CLEAR: begin
        state_d     = S_IDLE;
        coeff_num_d = '0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A sample is consumed once the FIR goes busy while it is offered.
    pend_d  = data_ready_in || (pend_q && !(dro_q && modwait));
    guard_d = (state_q == S_CLEAR);
    dro_d   = pend_d && (state_d == S_IDLE) && !guard_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      coeff_num_q <= '0;
      load_err_q  <= 1'b0;
      pend_q      <= 1'b0;
      guard_q     <= 1'b0;
      dro_q       <= 1'b0;
      load_q      <= 1'b0;
      clear_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      coeff_num_q <= coeff_num_d;
      load_err_q  <= load_err_d;
      pend_q      <= pend_d;
      guard_q     <= guard_d;
      dro_q       <= dro_d;
      load_q      <= (state_d == S_ISSUE);
      clear_q     <= (state_d == S_CLEAR);
      busy_q      <= (state_d != S_IDLE);
    end
  end

  assign coeff_num       = coeff_num_q;
  assign load_coeff      = load_q;
  assign data_ready_out  = dro_q;
  assign clear_new_coeff = clear_q;
  assign busy            = busy_q;
  assign load_err        = load_err_q;

endmodule

`default_nettype wire
